// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits num_pkts packets of pkt_len beats carrying an
// incrementing data word, with an optional idle gap between packets.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            pkt_len,
  input  logic [7:0]            num_pkts,
  input  logic [7:0]            gap_cycles,
  output logic [DATA_WIDTH-1:0] TDATA,
  output logic                  TVALID,
  input  logic                  TREADY,
  output logic                  TLAST,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pkts_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                  state_q, state_n;
  logic [7:0]              len_q, len_n;
  logic [7:0]              num_q, num_n;
  logic [7:0]              gap_q, gap_n;
  logic [7:0]              gap_cnt_q, gap_cnt_n;
  logic [8:0]              beat_q, beat_n;
  logic [DATA_WIDTH-1:0]   data_n;
  logic                    valid_n, last_n, busy_n, done_n;
  logic [7:0]              pkts_n;
  logic [7:0]              pkts_inc;

  // pkt_len of 0 encodes a 256-beat packet, so the last index is 255.
  function automatic logic is_last(input logic [7:0] len, input logic [8:0] beat);
    return beat == ((len == 8'd0) ? 9'd255 : {1'b0, len - 8'd1});
  endfunction

  assign pkts_inc = pkts_sent + 8'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_n   = state_q;
    len_n     = len_q;
    num_n     = num_q;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt_q;
    beat_n    = beat_q;
    data_n    = TDATA;
    valid_n   = TVALID;
    last_n    = TLAST;
    busy_n    = busy;
    done_n    = 1'b0;
    pkts_n    = pkts_sent;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_n  = pkt_len;
          num_n  = num_pkts;
          gap_n  = gap_cycles;
          pkts_n = 8'd0;
          data_n = '0;
          beat_n = 9'd0;
          if (num_pkts != 8'd0) begin
            state_n = SEND;
            valid_n = 1'b1;
            busy_n  = 1'b1;
            last_n  = is_last(pkt_len, 9'd0);
          end else begin
            done_n = 1'b1;
          end
        end
      end

      SEND: begin
        if (TVALID && TREADY) begin
          data_n = TDATA + DATA_WIDTH'(1);
          if (TLAST) begin
            pkts_n = pkts_inc;
            beat_n = 9'd0;
            if (pkts_inc == num_q) begin
              state_n = IDLE;
              valid_n = 1'b0;
              last_n  = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else if (gap_q == 8'd0) begin
              last_n = is_last(len_q, 9'd0);
            end else begin
              state_n   = GAP;
              valid_n   = 1'b0;
              last_n    = 1'b0;
              gap_cnt_n = gap_q;
            end
          end else begin
            beat_n = beat_q + 9'd1;
            last_n = is_last(len_q, beat_q + 9'd1);
          end
        end
      end

      GAP: begin
        // The counter is loaded with the full gap length; leave on its last idle cycle.
        gap_cnt_n = gap_cnt_q - 8'd1;
        if (gap_cnt_q == 8'd1) begin
          state_n = SEND;
          valid_n = 1'b1;
          last_n  = is_last(len_q, 9'd0);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= 8'd0;
      num_q     <= 8'd0;
      gap_q     <= 8'd0;
      gap_cnt_q <= 8'd0;
      beat_q    <= 9'd0;
      TDATA     <= '0;
      TVALID    <= 1'b0;
      TLAST     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= 8'd0;
    end else begin
      state_q   <= state_n;
      len_q     <= len_n;
      num_q     <= num_n;
      gap_q     <= gap_n;
      gap_cnt_q <= gap_cnt_n;
      beat_q    <= beat_n;
      TDATA     <= data_n;
      TVALID    <= valid_n;
      TLAST     <= last_n;
      busy      <= busy_n;
      done      <= done_n;
      pkts_sent <= pkts_n;
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen: back-to-back, gapped, backpressured,
// 256-beat, zero-packet, ignored-restart and mid-run reset scenarios.
module tb_axis_pkt_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  pkt_len;
  logic [7:0]  num_pkts;
  logic [7:0]  gap_cycles;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;
  logic        busy;
  logic        done;
  logic [7:0]  pkts_sent;

  int n_checks = 0;
  int n_fails  = 0;

  axis_pkt_gen #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pkt_len    (pkt_len),
    .num_pkts   (num_pkts),
    .gap_cycles (gap_cycles),
    .TDATA      (TDATA),
    .TVALID     (TVALID),
    .TREADY     (TREADY),
    .TLAST      (TLAST),
    .busy       (busy),
    .done       (done),
    .pkts_sent  (pkts_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] len, input logic [7:0] num, input logic [7:0] gap);
    pkt_len    = len;
    num_pkts   = num;
    gap_cycles = gap;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    logic [4:0] v2;
    logic [4:0] l5;

    reset = 1'b1; start = 1'b0; TREADY = 1'b0;
    pkt_len = 8'd0; num_pkts = 8'd0; gap_cycles = 8'd0;
    step(); step();
    check("rst_tvalid", TVALID, 0);
    check("rst_tdata", TDATA, 0);
    check("rst_tlast", TLAST, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkts", pkts_sent, 0);
    reset = 1'b0;
    step();
    TREADY = 1'b1;

    // Back-to-back: 2 packets of 4 beats, data 0..7.
    pulse_start(8'd4, 8'd2, 8'd0);
    check("b2b_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check("b2b_valid", TVALID, 1);
      check("b2b_data", TDATA, i);
      check("b2b_last", TLAST, (i % 4 == 3) ? 1 : 0);
      step();
    end
    check("b2b_done", done, 1);
    check("b2b_busy_off", busy, 0);
    check("b2b_valid_off", TVALID, 0);
    check("b2b_pkts", pkts_sent, 2);
    step();
    check("b2b_done_pulse", done, 0);

    // Gap of 2 between two 3-beat packets; done 8 cycles after first beat.
    pulse_start(8'd3, 8'd2, 8'd2);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      logic ev;
      ev = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      check("gap_valid", TVALID, ev);
      check("gap_done_early", done, 0);
      if (ev) begin
        check("gap_data", TDATA, k);
        check("gap_last", TLAST, (k % 3 == 2) ? 1 : 0);
        k++;
      end else begin
        check("gap_last_low", TLAST, 0);
      end
      step();
    end
    check("gap_done", done, 1);
    check("gap_pkts", pkts_sent, 2);
    step();

    // Random backpressure: 3 packets of 5 beats.
    pulse_start(8'd5, 8'd3, 8'd0);
    k = 0;
    cyc = 0;
    while (k < 15 && cyc < 500) begin
      TREADY = 1'($urandom_range(0, 1));
      check("bp_valid", TVALID, 1);
      check("bp_data", TDATA, k);
      check("bp_last", TLAST, (k % 5 == 4) ? 1 : 0);
      if (TREADY) k++;
      step();
      cyc++;
    end
    check("bp_beats_within_bound", k, 15);
    check("bp_done", done, 1);
    check("bp_pkts", pkts_sent, 3);
    TREADY = 1'b1;
    step();

    // pkt_len = 0 means 256 beats.
    pulse_start(8'd0, 8'd1, 8'd0);
    for (int i = 0; i < 256; i++) begin
      check("l256_valid", TVALID, 1);
      check("l256_data", TDATA, i);
      check("l256_last", TLAST, (i == 255) ? 1 : 0);
      step();
    end
    check("l256_done", done, 1);
    check("l256_pkts", pkts_sent, 1);
    step();

    // num_pkts = 0: immediate done, no beats.
    pulse_start(8'd4, 8'd0, 8'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", TVALID, 0);
    step();
    check("zero_done_pulse", done, 0);
    check("zero_valid2", TVALID, 0);

    // start held and config changed mid-run: original 2 x 2 beats with gap 1 completes.
    pulse_start(8'd2, 8'd2, 8'd1);
    start = 1'b1; pkt_len = 8'd7; num_pkts = 8'd5; gap_cycles = 8'd0;
    v2 = 5'b11011;
    l5 = 5'b10010;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      check("ign_valid", TVALID, v2[i]);
      check("ign_last", TLAST, l5[i]);
      if (v2[i]) begin
        check("ign_data", TDATA, k);
        k++;
      end
      if (i == 4) start = 1'b0;
      step();
    end
    check("ign_done", done, 1);
    check("ign_pkts", pkts_sent, 2);
    step();
    check("ign_no_restart", TVALID, 0);

    // Reset after 2 of 4 beats aborts at once; restart with TREADY low at release.
    pulse_start(8'd4, 8'd1, 8'd0);
    check("rr_data0", TDATA, 0);
    step();
    check("rr_data1", TDATA, 1);
    step();
    check("rr_data2", TDATA, 2);
    reset = 1'b1;
    #1;
    check("rr_valid_async", TVALID, 0);
    check("rr_data_async", TDATA, 0);
    check("rr_busy_async", busy, 0);
    check("rr_pkts_async", pkts_sent, 0);
    TREADY = 1'b0;
    step();
    reset = 1'b0;
    step();
    pulse_start(8'd2, 8'd1, 8'd0);
    check("rr2_valid", TVALID, 1);
    check("rr2_data0", TDATA, 0);
    check("rr2_pkts", pkts_sent, 0);
    step();
    check("rr2_stall_data", TDATA, 0);
    check("rr2_stall_valid", TVALID, 1);
    TREADY = 1'b1;
    step();
    check("rr2_data1", TDATA, 1);
    check("rr2_last", TLAST, 1);
    step();
    check("rr2_done", done, 1);
    check("rr2_pkts_final", pkts_sent, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
